// File: rtl/enemy_missile_launcher.sv
// Enemy missile launcher: samples 5 random bits per attempt, offers a launch, then cools down.
// Optional LAUNCH_X_CLAMP_EN folds out-of-range columns back into 0..LAST_COL.
module enemy_missile_launcher #(
  parameter int unsigned MAX_ACTIVE = 4,
  parameter int unsigned COOLDOWN   = 8,
  parameter int unsigned LAST_COL   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rand_bit,
  input  logic       missile_done,
  input  logic       launch_ready,
  output logic       launch_valid,
  output logic [3:0] launch_x,
  output logic [2:0] active_count
);

  localparam logic [3:0] LC   = 4'(LAST_COL);
  localparam logic [3:0] LC1  = 4'(LAST_COL + 1);
  localparam logic [2:0] MAXA = 3'(MAX_ACTIVE);
  localparam logic [7:0] CD   = 8'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_SAMPLE   = 2'd0,
    ST_OFFER    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t     r_state;
  logic [4:0] r_sample;
  logic [2:0] r_scnt;
  logic [7:0] r_cool;
  logic       r_valid;
  logic [3:0] r_x;
  logic [2:0] r_active;

  logic [4:0] w_next;
  logic [3:0] w_col;
  logic       w_hs;

  // New bit enters at the LSB, so the first sampled bit ends up as the fire flag.
  assign w_next = {r_sample[3:0], rand_bit};
  assign w_hs   = (r_state == ST_OFFER) && launch_ready;

`ifdef LAUNCH_X_CLAMP_EN
  logic [3:0] w_sub;
  always_comb begin
    w_sub = w_next[3:0] - LC1;
    w_col = w_next[3:0];
    if (w_next[3:0] > LC) begin
      w_col = (w_sub > LC) ? LC : w_sub;
    end
  end
`else
  assign w_col = w_next[3:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_SAMPLE;
      r_sample <= '0;
      r_scnt   <= '0;
      r_cool   <= '0;
      r_valid  <= 1'b0;
      r_x      <= '0;
      r_active <= '0;
    end else begin
      // A launch and a retirement in the same cycle cancel out.
      if (w_hs && !missile_done) begin
        r_active <= r_active + 3'd1;
      end else if (!w_hs && missile_done && (r_active != 3'd0)) begin
        r_active <= r_active - 3'd1;
      end

      case (r_state)
        ST_SAMPLE: begin
          if (tick) begin
            r_sample <= w_next;
            if (r_scnt == 3'd4) begin
              r_scnt <= '0;
              if (w_next[4] && (r_active < MAXA)) begin
                r_state <= ST_OFFER;
                r_valid <= 1'b1;
                r_x     <= w_col;
              end
            end else begin
              r_scnt <= r_scnt + 3'd1;
            end
          end
        end
        ST_OFFER: begin
          if (launch_ready) begin
            r_valid <= 1'b0;
            r_cool  <= CD;
            r_state <= ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (tick) begin
            if (r_cool <= 8'd1) begin
              r_cool  <= '0;
              r_scnt  <= '0;
              r_state <= ST_SAMPLE;
            end else begin
              r_cool <= r_cool - 8'd1;
            end
          end
        end
        default: r_state <= ST_SAMPLE;
      endcase
    end
  end

  assign launch_valid = r_valid;
  assign launch_x     = r_x;
  assign active_count = r_active;

endmodule

// File: tb/tb_enemy_missile_launcher.sv
// Directed bench for enemy_missile_launcher (default parameters; honours LAUNCH_X_CLAMP_EN).
module tb_enemy_missile_launcher;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       rand_bit;
  logic       missile_done;
  logic       launch_ready;
  logic       launch_valid;
  logic [3:0] launch_x;
  logic [2:0] active_count;

  int unsigned n_cmp;
  int unsigned n_err;

  enemy_missile_launcher #(
    .MAX_ACTIVE(4),
    .COOLDOWN  (8),
    .LAST_COL  (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .rand_bit    (rand_bit),
    .missile_done(missile_done),
    .launch_ready(launch_ready),
    .launch_valid(launch_valid),
    .launch_x    (launch_x),
    .active_count(active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LAUNCH_X_CLAMP_EN
  localparam logic [3:0] X13 = 4'd3;
  localparam logic [3:0] X15 = 4'd5;
`else
  localparam logic [3:0] X13 = 4'd13;
  localparam logic [3:0] X15 = 4'd15;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input logic b);
    tick     = 1'b1;
    rand_bit = b;
    cyc(1);
    tick     = 1'b0;
    rand_bit = 1'b0;
  endtask

  // bits[4] is delivered first
  task automatic send4(input logic [4:0] bits);
    for (int i = 4; i >= 1; i--) do_tick(bits[i]);
  endtask

  task automatic send5(input logic [4:0] bits);
    send4(bits);
    do_tick(bits[0]);
  endtask

  task automatic handshake;
    launch_ready = 1'b1;
    cyc(1);
    launch_ready = 1'b0;
  endtask

  task automatic done_pulse;
    missile_done = 1'b1;
    cyc(1);
    missile_done = 1'b0;
  endtask

  task automatic cooldown8;
    repeat (8) do_tick(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    tick = 1'b0;
    rand_bit = 1'b0;
    missile_done = 1'b0;
    launch_ready = 1'b0;
    cyc(3);
    check("rst_valid", launch_valid, 0);
    check("rst_x", launch_x, 0);
    check("rst_count", active_count, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1,0,1,0,1 -> fire, column 5, one cycle after the 5th tick
    send4(5'b10101);
    check("pre5_valid", launch_valid, 0);
    do_tick(1'b1);
    check("lat_valid", launch_valid, 1);
    check("lat_x", launch_x, 5);
    do_tick(1'b0);
    do_tick(1'b1);
    cyc(2);
    check("hold_valid", launch_valid, 1);
    check("hold_x", launch_x, 5);

    handshake();
    check("hs1_count", active_count, 1);
    check("hs1_valid", launch_valid, 0);

    // 8 cooldown ticks then 5 sample ticks; only the 13th launches
    repeat (12) do_tick(1'b1);
    check("cd_nolaunch", launch_valid, 0);
    do_tick(1'b1);
    check("cd_launch", launch_valid, 1);
    check("x_raw15", launch_x, X15);
    handshake();
    check("hs2_count", active_count, 2);
    cooldown8();

    send5(5'b01101);
    check("nofire_valid", launch_valid, 0);
    send5(5'b11101);
    check("fresh_valid", launch_valid, 1);
    check("x_raw13", launch_x, X13);

    missile_done = 1'b1;
    handshake();
    missile_done = 1'b0;
    check("hs_done_count", active_count, 2);
    check("hs_done_valid", launch_valid, 0);
    cooldown8();

    send5(5'b10001);
    check("x1", launch_x, 1);
    handshake();
    cooldown8();
    send5(5'b10010);
    check("x2", launch_x, 2);
    handshake();
    check("full_count", active_count, 4);
    cooldown8();

    send5(5'b10011);
    cyc(2);
    check("full_nolaunch", launch_valid, 0);
    check("full_count2", active_count, 4);
    done_pulse();
    check("dec_count", active_count, 3);
    send5(5'b10110);
    check("after_dec_valid", launch_valid, 1);
    check("x6", launch_x, 6);

    // asynchronous reset during an offer
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", launch_valid, 0);
    check("arst_count", active_count, 0);
    check("arst_x", launch_x, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    handshake();
    check("post_rst_nohs", active_count, 0);
    done_pulse();
    check("done_at_zero", active_count, 0);
    send4(5'b11101);
    check("post_rst_4", launch_valid, 0);
    do_tick(1'b1);
    check("post_rst_5", launch_valid, 1);
    check("post_rst_x", launch_x, X13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
